// File: rtl/bin2bcd_display.sv
// bin2bcd_display: samples a binary value periodically or on request, converts it to
// BCD with a double-dabble engine, and presents held digits plus blank/sign/overflow flags.
`default_nettype none

module bin2bcd_display #(
  parameter int WIDTH      = 16,
  parameter int DIGITS     = 5,
  parameter int UPDATE_DIV = 5000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_signed,
  input  logic                  i_update,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic [DIGITS-1:0]     o_blank,
  output logic                  o_negative,
  output logic                  o_overflow,
  output logic                  o_valid,
  output logic                  o_busy
);

  // Decimal digits needed for 2^w-1, i.e. ceil(w*log10(2)).
  function automatic int calc_acc_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int ACC_DIGITS = calc_acc_digits(WIDTH);
  localparam int ACC_W      = 4 * ACC_DIGITS;
  localparam int TICK_W     = $clog2(UPDATE_DIV);
  localparam int BIT_W      = $clog2(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic                pending;
  logic                start_req;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_adj;
  logic [WIDTH-1:0]    mag;
  logic [ACC_W+WIDTH-1:0] shifted;
  logic                sign;
  logic [BIT_W-1:0]    bit_cnt;
  logic                value_neg;
  logic [4*DIGITS-1:0] present_raw;
  logic [4*DIGITS-1:0] digits_next;
  logic [DIGITS-1:0]   blank_next;
  logic                overflow;
  logic                zero_above;

  assign tick      = (tick_cnt == TICK_W'(UPDATE_DIV - 1));
  assign start_req = i_update | tick | pending;
  assign value_neg = i_signed & i_value[WIDTH-1];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
  end

  assign shifted = {acc_adj, mag} << 1;

  // Presented digits beyond the accumulator width read as zero.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g < ACC_DIGITS) begin : g_src
      assign present_raw[4*g +: 4] = acc[4*g +: 4];
    end else begin : g_pad
      assign present_raw[4*g +: 4] = 4'd0;
    end
  end

  if (ACC_DIGITS > DIGITS) begin : g_ovf
    assign overflow = |acc[ACC_W-1:4*DIGITS];
  end else begin : g_no_ovf
    assign overflow = 1'b0;
  end

  always_comb begin
    zero_above = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (present_raw[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above & ~overflow;
    end
    digits_next = overflow ? {DIGITS{4'h9}} : present_raw;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      acc        <= '0;
      mag        <= '0;
      sign       <= 1'b0;
      bit_cnt    <= '0;
      o_digits   <= '0;
      o_blank    <= BLANK_RST;
      o_negative <= 1'b0;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            pending <= 1'b0;
            sign    <= value_neg;
            mag     <= value_neg ? (~i_value + WIDTH'(1)) : i_value;
            acc     <= '0;
            bit_cnt <= '0;
            o_busy  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (start_req) pending <= 1'b1;
          acc     <= shifted[ACC_W+WIDTH-1:WIDTH];
          mag     <= shifted[WIDTH-1:0];
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (start_req) pending <= 1'b1;
          o_digits   <= digits_next;
          o_blank    <= blank_next;
          o_negative <= sign;
          o_overflow <= overflow;
          o_valid    <= 1'b1;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_display.sv
// Testbench for bin2bcd_display: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literals (16-bit/5-digit and 8-bit/2-digit).
`timescale 1ns/1ps

module tb_bin2bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] v16 = '0;
  logic        s16 = 1'b0, u16 = 1'b0;
  logic [19:0] d16;
  logic [4:0]  b16;
  logic        n16, ov16, va16, bu16;

  logic [7:0]  v8 = '0;
  logic        s8 = 1'b0, u8 = 1'b0;
  logic [7:0]  d8;
  logic [1:0]  b8;
  logic        n8, ov8, va8, bu8;

  int checks = 0;
  int failures = 0;
  bit dut8_done = 1'b0;

  bin2bcd_display #(.WIDTH(16), .DIGITS(5), .UPDATE_DIV(64)) dut (
    .i_clock(clk), .i_reset(rst), .i_value(v16), .i_signed(s16), .i_update(u16),
    .o_digits(d16), .o_blank(b16), .o_negative(n16), .o_overflow(ov16),
    .o_valid(va16), .o_busy(bu16)
  );

  bin2bcd_display #(.WIDTH(8), .DIGITS(2), .UPDATE_DIV(50000)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_value(v8), .i_signed(s8), .i_update(u8),
    .o_digits(d8), .o_blank(b8), .o_negative(n8), .o_overflow(ov8),
    .o_valid(va8), .o_busy(bu8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Decimal formatting from plain arithmetic: digit i = (mag / 10^i) % 10.
  function automatic void fmt(input longint unsigned val, input bit sgn, input int w, input int nd,
                              output logic [39:0] dig, output logic [9:0] blk,
                              output bit neg, output bit ovf);
    longint unsigned mag, p;
    neg = sgn && val[w-1];
    mag = neg ? ((64'd1 << w) - val) : val;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    ovf = (mag >= p);
    dig = '0;
    blk = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      dig[4*i +: 4] = ovf ? 4'd9 : 4'((mag / p) % 10);
      if (i > 0) blk[i] = !ovf && (mag < p);
      p = p * 10;
    end
  endfunction

  // Reference model for the 16-bit instance: request timing plus arithmetic result.
  int          n_edges = 0;
  int          rem = 0;
  bit          pend = 1'b0;
  logic [15:0] cap_v;
  bit          cap_s;
  logic [19:0] e_dig = '0;
  logic [4:0]  e_blank = 5'b11110;
  bit          e_neg = 0, e_ovf = 0, e_valid = 0, e_busy = 0;
  bit          model_on = 1'b0;
  bit          m_tick, m_req;
  logic [39:0] fd;
  logic [9:0]  fb;
  bit          fn, fo;

  always @(posedge clk) begin
    if (rst) begin
      n_edges = 0; rem = 0; pend = 0;
      e_dig = '0; e_blank = 5'b11110; e_neg = 0; e_ovf = 0; e_valid = 0; e_busy = 0;
    end else begin
      m_tick = (n_edges % 64) == 63;
      n_edges++;
      m_req = u16 || m_tick || pend;
      e_valid = 0;
      if (rem == 0) begin
        if (m_req) begin
          cap_v = v16; cap_s = s16; rem = 17; pend = 0; e_busy = 1;
        end
      end else begin
        if (m_req) pend = 1;
        rem--;
        if (rem == 0) begin
          fmt(64'(cap_v), cap_s, 16, 5, fd, fb, fn, fo);
          e_dig = fd[19:0]; e_blank = fb[4:0]; e_neg = fn; e_ovf = fo;
          e_valid = 1; e_busy = 0;
        end
      end
    end
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_digits",   64'(d16),  64'(e_dig));
      chk("m_blank",    64'(b16),  64'(e_blank));
      chk("m_negative", 64'(n16),  64'(e_neg));
      chk("m_overflow", 64'(ov16), 64'(e_ovf));
      chk("m_valid",    64'(va16), 64'(e_valid));
      chk("m_busy",     64'(bu16), 64'(e_busy));
    end
  end

  task automatic request16(input logic [15:0] v, input logic s);
    v16 = v; s16 = s; u16 = 1'b1;
    @(negedge clk);
    u16 = 1'b0;
  endtask

  task automatic wait_valid16(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (va16) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL valid16_timeout actual=none required=pulse");
    end
  endtask

  initial begin
    int lat, cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", 64'(d16), 64'h00000);
    chk("rst_blank",  64'(b16), 64'b11110);
    chk("rst_valid",  64'(va16), 64'd0);
    chk("rst_busy",   64'(bu16), 64'd0);
    rst = 1'b0;

    request16(16'd1234, 1'b0);
    chk("busy_after_start", 64'(bu16), 64'd1);
    wait_valid16(lat);
    chk("lat_1234",    64'(lat), 64'd17);
    chk("dig_1234",    64'(d16), 64'h01234);
    chk("blank_1234",  64'(b16), 64'b10000);
    chk("neg_1234",    64'(n16), 64'd0);

    request16(16'hFFFF, 1'b1);
    wait_valid16(lat);
    chk("dig_m1",   64'(d16), 64'h00001);
    chk("blank_m1", 64'(b16), 64'b11110);
    chk("neg_m1",   64'(n16), 64'd1);

    request16(16'h8000, 1'b1);
    wait_valid16(lat);
    chk("dig_min", 64'(d16), 64'h32768);
    chk("neg_min", 64'(n16), 64'd1);
    chk("ovf_min", 64'(ov16), 64'd0);

    request16(16'd65535, 1'b0);
    wait_valid16(lat);
    chk("dig_max", 64'(d16), 64'h65535);
    chk("neg_max", 64'(n16), 64'd0);

    // Free-running ticks only: steady spacing between valid pulses.
    wait_valid16(lat);
    wait_valid16(lat);
    wait_valid16(lat);
    chk("tick_period", 64'(lat), 64'd64);

    // Two requests during SHIFT with a value change: one extra conversion.
    request16(16'd1111, 1'b0);
    @(negedge clk);
    v16 = 16'd2222; u16 = 1'b1;
    @(negedge clk);
    u16 = 1'b0;
    @(negedge clk);
    u16 = 1'b1;
    @(negedge clk);
    u16 = 1'b0;
    wait_valid16(lat);
    chk("lat_1111", 64'(lat), 64'd13);
    chk("dig_1111", 64'(d16), 64'h01111);
    wait_valid16(lat);
    chk("pend_gap",  64'(lat), 64'd18);
    chk("dig_2222", 64'(d16), 64'h02222);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (va16) cnt++;
    end
    chk("no_extra_valid", 64'(cnt), 64'd0);

    // Reset at edge k+8 of a conversion.
    wait_valid16(lat);
    request16(16'd4321, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (va16) cnt++;
    end
    chk("abort_no_valid", 64'(cnt), 64'd0);
    chk("abort_digits",   64'(d16), 64'h00000);
    chk("abort_blank",    64'(b16), 64'b11110);
    chk("abort_busy",     64'(bu16), 64'd0);
    rst = 1'b0;
    request16(16'd4321, 1'b0);
    wait_valid16(lat);
    chk("lat_4321", 64'(lat), 64'd17);
    chk("dig_4321", 64'(d16), 64'h04321);

    for (int i = 0; i < 1000 && !dut8_done; i++) @(negedge clk);
    if (!dut8_done) begin
      checks++;
      failures++;
      $display("FAIL dut8_timeout actual=running required=done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Narrow instance: overflow saturation and blanking.
  initial begin
    int lat8;
    logic [39:0] xd;
    logic [9:0]  xb;
    bit          xn, xo;
    @(negedge clk);
    while (rst) @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin v8 = 8'd200; s8 = 1'b0; end
        1: begin v8 = 8'd7;   s8 = 1'b0; end
        default: begin v8 = 8'hF9; s8 = 1'b1; end
      endcase
      u8 = 1'b1;
      @(negedge clk);
      u8 = 1'b0;
      lat8 = -1;
      for (int i = 1; i <= 100; i++) begin
        @(negedge clk);
        if (va8) begin
          lat8 = i;
          break;
        end
      end
      chk("d8_lat", 64'(lat8), 64'd9);
      fmt(64'(v8), s8, 8, 2, xd, xb, xn, xo);
      chk("d8_model_digits", 64'(d8), 64'(xd[7:0]));
      chk("d8_model_blank",  64'(b8), 64'(xb[1:0]));
      chk("d8_model_ovf",    64'(ov8), 64'(xo));
      chk("d8_model_neg",    64'(n8), 64'(xn));
      case (t)
        0: begin
          chk("d8_200_digits", 64'(d8), 64'h99);
          chk("d8_200_ovf",    64'(ov8), 64'd1);
          chk("d8_200_blank",  64'(b8), 64'b00);
        end
        1: begin
          chk("d8_7_digits", 64'(d8), 64'h07);
          chk("d8_7_blank",  64'(b8), 64'b10);
          chk("d8_7_ovf",    64'(ov8), 64'd0);
        end
        default: begin
          chk("d8_m7_digits", 64'(d8), 64'h07);
          chk("d8_m7_neg",    64'(n8), 64'd1);
        end
      endcase
    end
    dut8_done = 1'b1;
  end

endmodule
